encoder_scanner: RTL
====================

# encoder_scanner

Time-multiplexed scan controller for 8 rotary encoders sharing one A/B input pair through an external analog mux. It steps a 3-bit mux select across the channels and waits a settle interval on each one. It then samples the synchronised A/B level and applies x4 quadrature decoding against that channel's stored previous state. Signed 16-bit positions live in a CPU-visible register file, grouped two per 32-bit word.

## Interface
- SETTLE_CYCLES, 16, cycles the select is held before sampling; legal range 3..255, which covers 2-flop synchroniser latency plus mux settling.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- reg_we  input  4  byte write enables. A half-word is written only when both of its byte enables are set: [1:0] for the low half, [3:2] for the high half.
- reg_addr  input  2  word select. Word i holds channel 2i in [15:0] and channel 2i+1 in [31:16].
- reg_data  input  32  write data.
- reg_q  output  32  read data. Combinational from reg_addr and current positions.
- sel  output  3  mux select, i.e. the channel currently being scanned.
- frame  output  1  one-cycle pulse when the channel 7 update completes.
- a  input  1  shared encoder A from the mux. Asynchronous; synchronised internally.
- b  input  1  shared encoder B from the mux. Asynchronous; synchronised internally.

## Operation
- a and b each pass through a 2-flop synchroniser. The sampled value is ab = {a_s, b_s}, with a as the MSB.
- The FSM has three states: SETTLE, SAMPLE, UPDATE.
  - SETTLE: the counter counts from 0 to SETTLE_CYCLES-1 with sel stable, then goes to SAMPLE.
  - SAMPLE: captures ab into cur, then goes to UPDATE.
  - UPDATE: applies the decode to channel sel and stores cur as prev[sel]. It then increments sel (7 wraps to 0), clears the counter and goes to SETTLE.
- Per-channel state: prev[2], primed, and pos[16].
- Decode rules, applied in UPDATE:
  - Channel not primed: set primed, store prev, position unchanged. The first sample after reset only seeds prev.
  - Forward sequence 00->01->11->10->00: +1.
  - Reverse sequence 00->10->11->01->00: -1.
  - cur == prev: no change.
  - Both bits changed (invalid): no change. prev is still updated.
- Arithmetic is 16-bit modular: 0xFFFF+1 = 0x0000 and 0x0000-1 = 0xFFFF.
- CPU write to a half-word sets that channel's position to reg_data.
  - A write does not touch prev or primed.
  - If a write and an UPDATE for the same channel fall in the same cycle, the write wins and that step is discarded.
  - Writes to other channels during an UPDATE are independent.
- Reset (asynchronous, at any time including mid-scan) sets:
  - state = SETTLE, counter = 0, sel = 0, frame = 0;
  - every pos = 0, every primed = 0, every prev = 00;
  - synchroniser flops = 0.

## Timing
- Per-channel slot: SETTLE_CYCLES + 2 cycles. Full frame: 8 × (SETTLE_CYCLES + 2) cycles; 144 cycles at the default.
- sel changes on the clock edge that ends UPDATE.
- SAMPLE sees the A/B level that was at the pins at least 2 cycles before the SAMPLE edge.
- pos updates on the UPDATE edge and is visible on reg_q in the next cycle. The read path is combinational from the registers.
- frame is high for the cycle immediately after the channel 7 UPDATE edge.
- After reset release:
  - first sel 0 UPDATE ends at cycle SETTLE_CYCLES + 2;
  - first frame pulse is at cycle 8 × (SETTLE_CYCLES + 2);
  - all channels are primed after the first frame.
- Detents faster than one transition per frame alias. Encoder rate is limited to one quadrature edge per frame period.

## Test plan
- Reset and scan:
  - Stimulus: hold a=b=0 and release rst_n.
  - Required: reg_q = 0 on every address; sel steps 0..7 every 18 cycles; frame pulses every 144 cycles; all positions stay 0.
- Forward count:
  - Stimulus: drive channel 3's mux input through 00,01,11,10,00, one step per frame, after priming.
  - Required: pos[3] = 4, visible as reg_addr=1 reg_q[31:16] = 0x0004; other channels 0.
- Reverse and wrap:
  - Stimulus: channel 0 at 0; one reverse step (00->10).
  - Required: reg_q[15:0] at addr 0 = 0xFFFF. Then one forward step returns it to 0x0000.
- Invalid transition:
  - Stimulus: channel 5 goes 00->11 within one frame.
  - Required: pos[5] unchanged. A next-frame step 11->10 gives +1.
- Write collision:
  - Stimulus: write reg_we=4'b1100, addr 3, data 0x1234_0000 on the exact UPDATE cycle of channel 7 while it steps forward.
  - Required: pos[7] = 0x1234; the low half of addr 3 is unchanged. A write with reg_we=4'b0100 changes nothing.
- Reset mid-scan:
  - Stimulus: assert rst_n low during SETTLE of channel 4, with nonzero positions.
  - Required: immediately sel = 0, frame = 0, all reg_q = 0. After release, the first frame only primes and produces no counts.

Source files
------------

// File: rtl/encoder_scanner.sv
// encoder_scanner
//   Scans 8 rotary encoders that share one A/B pair through an external
//   analog mux. Each channel gets a slot of SETTLE_CYCLES + 2 cycles:
//   SETTLE (hold sel), SAMPLE (capture synchronised A/B), UPDATE (x4
//   quadrature decode against the channel's previous A/B state).
//   Positions are 16-bit modular counters, readable and writable by a CPU.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   reg_we    byte write enables; [1:0] both set -> low half, [3:2] both set -> high half
//   reg_addr  word select; word i = {pos[2i+1], pos[2i]}
//   reg_data  write data
//   reg_q     read data, combinational from reg_addr and the positions
//   sel       mux select, channel currently being scanned
//   frame     one-cycle pulse after the channel 7 update
//   a, b      shared encoder inputs (asynchronous)
module encoder_scanner #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  reg_we,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic [31:0] reg_q,
    output logic [2:0]  sel,
    output logic        frame,
    input  logic        a,
    input  logic        b
);

    typedef enum logic [1:0] {SETTLE, SAMPLE, UPDATE} state_t;

    state_t             state;
    logic [7:0]         cnt;
    logic [1:0]         cur;
    logic               a_p0, a_p1, b_p0, b_p1;
    logic [1:0]         prev [8];
    logic [7:0]         primed;
    logic signed [15:0] pos [8];
    logic [7:0]         wr_ch;
    logic               wr_lo, wr_hi;

    // Position of a Gray code value along the forward sequence 00,01,11,10.
    function automatic logic [1:0] gray_idx(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // One step forward along the sequence is +1, one step back is -1;
    // no change or a two-bit jump (distance 2) contributes nothing.
    function automatic logic signed [15:0] quad_step(input logic [1:0] p,
                                                     input logic [1:0] c);
        logic [1:0] d;
        d = gray_idx(c) - gray_idx(p);
        case (d)
            2'd1:    return 16'sd1;
            2'd3:    return -16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    assign wr_lo = &reg_we[1:0];
    assign wr_hi = &reg_we[3:2];

    always_comb begin
        wr_ch = '0;
        for (int i = 0; i < 8; i++) begin
            if (reg_addr == 2'(i >> 1))
                wr_ch[i] = (i % 2 == 1) ? wr_hi : wr_lo;
        end
    end

    always_comb begin
        reg_q = {pos[{reg_addr, 1'b1}], pos[{reg_addr, 1'b0}]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SETTLE;
            cnt    <= '0;
            sel    <= '0;
            frame  <= 1'b0;
            cur    <= '0;
            a_p0   <= 1'b0;
            a_p1   <= 1'b0;
            b_p0   <= 1'b0;
            b_p1   <= 1'b0;
            primed <= '0;
            for (int i = 0; i < 8; i++) begin
                prev[i] <= '0;
                pos[i]  <= '0;
            end
        end else begin
            // synchroniser stage p0 -> p1
            a_p0  <= a;
            a_p1  <= a_p0;
            b_p0  <= b;
            b_p1  <= b_p0;
            frame <= 1'b0;

            case (state)
                SETTLE: begin
                    if (cnt == 8'(SETTLE_CYCLES - 1)) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    cur   <= {a_p1, b_p1};
                    state <= UPDATE;
                end
                UPDATE: begin
                    if (!primed[sel])
                        primed[sel] <= 1'b1;
                    else
                        pos[sel] <= pos[sel] + quad_step(prev[sel], cur);
                    prev[sel] <= cur;
                    frame     <= (sel == 3'd7);
                    sel       <= sel + 3'd1;
                    cnt       <= '0;
                    state     <= SETTLE;
                end
                default: begin
                    state <= SETTLE;
                    cnt   <= '0;
                end
            endcase

            // CPU writes come last so they override a same-cycle decode step.
            for (int i = 0; i < 8; i++) begin
                if (wr_ch[i])
                    pos[i] <= (i % 2 == 1) ? $signed(reg_data[31:16])
                                           : $signed(reg_data[15:0]);
            end
        end
    end

endmodule
